// File: rtl/intersection_scheduler_pkg.sv
// rtl/intersection_scheduler_pkg.sv - shared state codes, lamp encodings and default phase durations
package intersection_scheduler_pkg;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_MAIN_G  = 3'd1;
    localparam logic [2:0] ST_MAIN_Y  = 3'd2;
    localparam logic [2:0] ST_ALL_RED = 3'd3;
    localparam logic [2:0] ST_SIDE_G  = 3'd4;
    localparam logic [2:0] ST_SIDE_Y  = 3'd5;
    localparam logic [2:0] ST_WALK    = 3'd6;

    localparam logic [2:0] LAMP_RED = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b100;

    localparam int DEF_T_MIN_GREEN = 6;
    localparam int DEF_T_MAX_SIDE  = 12;
    localparam int DEF_T_YELLOW    = 3;
    localparam int DEF_T_ALL_RED   = 2;
    localparam int DEF_T_WALK      = 5;

    // Phase that follows the all-red clearance interval
    typedef enum logic [1:0] {
        RET_MAIN = 2'd0,
        RET_SIDE = 2'd1,
        RET_WALK = 2'd2
    } ret_sel_e;

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// rtl/intersection_scheduler_phase_timer.sv - per-phase tick counter with saturation, done flag and remaining count
module intersection_scheduler_phase_timer
    import intersection_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       step_i,
    input  logic [3:0] limit_i,
    output logic [3:0] count_o,
    output logic       done_o,
    output logic [3:0] remaining_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Clear on phase change, otherwise count steps up to the phase limit and stays there
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 4'd0;
        end else if (step_i && (count_q < limit_i)) begin
            count_d = count_q + 4'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign done_o      = step_i && (count_q == (limit_i - 4'd1));
    assign remaining_o = (count_q < limit_i) ? (limit_i - count_q) : 4'd0;

endmodule

// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - three-way intersection phase scheduler with latched requests
module intersection_scheduler
    import intersection_scheduler_pkg::*;
#(
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_MAX_SIDE  = DEF_T_MAX_SIDE,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALL_RED   = DEF_T_ALL_RED,
    parameter int T_WALK      = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       en,
    input  logic       req_side,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       ped_walk,
    output logic       ped_wait,
    output logic       side_wait,
    output logic [3:0] remaining,
    output logic [2:0] phase
);

    localparam logic [3:0] D_MIN_GREEN = 4'(T_MIN_GREEN);
    localparam logic [3:0] D_MAX_SIDE  = 4'(T_MAX_SIDE);
    localparam logic [3:0] D_YELLOW    = 4'(T_YELLOW);
    localparam logic [3:0] D_ALL_RED   = 4'(T_ALL_RED);
    localparam logic [3:0] D_WALK      = 4'(T_WALK);

    logic [2:0] state_q, state_d;
    ret_sel_e   ret_sel_q, ret_sel_d;
    logic       side_wait_q, side_wait_d;
    logic       ped_wait_q, ped_wait_d;
    logic       step;
    logic [3:0] limit;
    logic [3:0] count;
    logic       done;
    logic [3:0] remaining_cnt;

    assign step = tick && en;

    // Duration of the current phase; main green uses its minimum as the saturation point
    always_comb begin
        case (state_q)
            ST_MAIN_G: limit = D_MIN_GREEN;
            ST_MAIN_Y: limit = D_YELLOW;
            ST_SIDE_G: limit = D_MAX_SIDE;
            ST_SIDE_Y: limit = D_YELLOW;
            ST_WALK:   limit = D_WALK;
            default:   limit = D_ALL_RED;
        endcase
    end

    intersection_scheduler_phase_timer u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (state_d != state_q),
        .step_i      (step),
        .limit_i     (limit),
        .count_o     (count),
        .done_o      (done),
        .remaining_o (remaining_cnt)
    );

    // Phase sequencing; every change of right-of-way goes through ALL_RED
    always_comb begin
        state_d   = state_q;
        ret_sel_d = ret_sel_q;
        case (state_q)
            ST_INIT: begin
                if (done) state_d = ST_MAIN_G;
            end
            ST_MAIN_G: begin
                if (step && (count >= D_MIN_GREEN) && (side_wait_q || ped_wait_q)) begin
                    state_d = ST_MAIN_Y;
                end
            end
            ST_MAIN_Y: begin
                if (done) begin
                    state_d   = ST_ALL_RED;
                    ret_sel_d = side_wait_q ? RET_SIDE : RET_WALK;
                end
            end
            ST_ALL_RED: begin
                if (done) begin
                    case (ret_sel_q)
                        RET_SIDE: state_d = ST_SIDE_G;
                        RET_WALK: state_d = ST_WALK;
                        default:  state_d = ST_MAIN_G;
                    endcase
                end
            end
            ST_SIDE_G: begin
                if (done || (step && !req_side && (count >= (D_MIN_GREEN - 4'd1)))) begin
                    state_d = ST_SIDE_Y;
                end
            end
            ST_SIDE_Y: begin
                if (done) begin
                    state_d   = ST_ALL_RED;
                    ret_sel_d = ped_wait_q ? RET_WALK : RET_MAIN;
                end
            end
            ST_WALK: begin
                if (done) begin
                    state_d   = ST_ALL_RED;
                    ret_sel_d = RET_MAIN;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Request latches capture even while frozen; clearing on service entry overrides a same-cycle set
    always_comb begin
        side_wait_d = side_wait_q || (req_side && (state_q != ST_SIDE_G));
        ped_wait_d  = ped_wait_q || (ped_req && (state_q != ST_WALK));
        if ((state_d == ST_SIDE_G) && (state_q != ST_SIDE_G)) side_wait_d = 1'b0;
        if ((state_d == ST_WALK) && (state_q != ST_WALK))     ped_wait_d  = 1'b0;
    end

    // State, return selector and request latch registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            ret_sel_q   <= RET_MAIN;
            side_wait_q <= 1'b0;
            ped_wait_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_sel_q   <= ret_sel_d;
            side_wait_q <= side_wait_d;
            ped_wait_q  <= ped_wait_d;
        end
    end

    assign main_light = (state_q == ST_MAIN_G) ? LAMP_GRN :
                        (state_q == ST_MAIN_Y) ? LAMP_YEL : LAMP_RED;
    assign side_light = (state_q == ST_SIDE_G) ? LAMP_GRN :
                        (state_q == ST_SIDE_Y) ? LAMP_YEL : LAMP_RED;
    assign ped_walk   = (state_q == ST_WALK);
    assign ped_wait   = ped_wait_q;
    assign side_wait  = side_wait_q;
    assign remaining  = remaining_cnt;
    assign phase      = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb/tb_intersection_scheduler.sv - scoreboard bench for intersection_scheduler against a behavioural model
module tb_intersection_scheduler;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       en;
    logic       req_side;
    logic       ped_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       ped_walk;
    logic       ped_wait;
    logic       side_wait;
    logic [3:0] remaining;
    logic [2:0] phase;

    intersection_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .en         (en),
        .req_side   (req_side),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .ped_walk   (ped_walk),
        .ped_wait   (ped_wait),
        .side_wait  (side_wait),
        .remaining  (remaining),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       walk;
        logic       pw;
        logic       sw;
        logic [3:0] rem;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state: phase number, ticks spent in it, pending flags, phase after clearance
    int m_ph   = 0;
    int m_el   = 0;
    bit m_sw   = 0;
    bit m_pw   = 0;
    int m_dest = 1;

    function automatic int dur_of(input int p);
        case (p)
            1:       return 6;
            2:       return 3;
            4:       return 12;
            5:       return 3;
            6:       return 5;
            default: return 2;
        endcase
    endfunction

    always @(posedge clk) begin
        int   nxt;
        bit   tk;
        bit   last;
        exp_t e;
        if (!rst_n) begin
            m_ph = 0; m_el = 0; m_sw = 0; m_pw = 0; m_dest = 1;
        end else begin
            tk   = tick && en;
            last = tk && (m_el + 1 >= dur_of(m_ph));
            nxt  = m_ph;
            case (m_ph)
                0: if (last) nxt = 1;
                1: if (tk && m_el >= 6 && (m_sw || m_pw)) nxt = 2;
                2: if (last) begin nxt = 3; m_dest = m_sw ? 4 : 6; end
                3: if (last) nxt = m_dest;
                4: if (last || (tk && !req_side && m_el + 1 >= 6)) nxt = 5;
                5: if (last) begin nxt = 3; m_dest = m_pw ? 6 : 1; end
                6: if (last) begin nxt = 3; m_dest = 1; end
                default: nxt = 0;
            endcase
            if (req_side && m_ph != 4) m_sw = 1;
            if (ped_req && m_ph != 6)  m_pw = 1;
            if (nxt == 4 && m_ph != 4) m_sw = 0;
            if (nxt == 6 && m_ph != 6) m_pw = 0;
            if (nxt != m_ph) m_el = 0;
            else if (tk)     m_el = m_el + 1;
            m_ph = nxt;
        end
        e.ph   = 3'(m_ph);
        e.ml   = (m_ph == 1) ? 3'b100 : (m_ph == 2) ? 3'b010 : 3'b001;
        e.sl   = (m_ph == 4) ? 3'b100 : (m_ph == 5) ? 3'b010 : 3'b001;
        e.walk = (m_ph == 6);
        e.pw   = m_pw;
        e.sw   = m_sw;
        e.rem  = (m_el < dur_of(m_ph)) ? 4'(dur_of(m_ph) - m_el) : 4'd0;
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per clock, compared away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("phase", {1'b0, phase}, {1'b0, e.ph});
            chk("main_light", {1'b0, main_light}, {1'b0, e.ml});
            chk("side_light", {1'b0, side_light}, {1'b0, e.sl});
            chk("ped_walk", {3'b0, ped_walk}, {3'b0, e.walk});
            chk("ped_wait", {3'b0, ped_wait}, {3'b0, e.pw});
            chk("side_wait", {3'b0, side_wait}, {3'b0, e.sw});
            chk("remaining", remaining, e.rem);
            chk("both_groups_open", {3'b0, (main_light != 3'b001) && (side_light != 3'b001)}, 4'd0);
        end
    end

    task automatic drive(input logic t, input logic e, input logic rs, input logic pr, input logic rn);
        tick = t; en = e; req_side = rs; ped_req = pr; rst_n = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n = 0;
        while (m_ph != p && n < budget) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            n++;
        end
        if (m_ph != p) begin
            errors++;
            $display("FAIL wait_phase: phase %0d not reached within %0d cycles (model at %0d)", p, budget, m_ph);
        end
    endtask

    initial begin
        tick = 0; en = 1; req_side = 0; ped_req = 0; rst_n = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Idle: main green should persist
        for (int i = 0; i < 120; i++) drive(1'(i % 2), 1'b1, 1'b0, 1'b0, 1'b1);
        // Single side pulse, side released
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 60; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        // Side held: max green, re-request afterwards
        for (int i = 0; i < 60; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        // Side and pedestrian together, extra button presses throughout (including during walk)
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 80; i++) drive(1'b1, 1'b1, 1'b0, 1'(($urandom % 4) == 0), 1'b1);
        // Freeze during main yellow
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_phase(2, 200);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        // Reset in the middle of side green
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_phase(4, 200);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'(($urandom % 3) == 0), 1'(($urandom % 8) != 0), 1'(($urandom % 6) == 0),
                  1'(($urandom % 10) == 0), 1'(($urandom % 300) != 0));
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
